// File: rtl/calc_sseg_if.sv
// rtl/calc_sseg_if.sv - request/response and display bundle for calc_sseg_scan
interface calc_sseg_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [1:0]   op_sel;
    logic         busy;
    logic         done;
    logic         cout;
    logic         overf;
    logic [6:0]   sseg;
    logic [7:0]   an;
    logic         DP;

    modport master (
        output start, x, y, op_sel,
        input  busy, done, cout, overf, sseg, an, DP
    );

    modport slave (
        input  start, x, y, op_sel,
        output busy, done, cout, overf, sseg, an, DP
    );
endinterface

// File: rtl/calc_sseg_scan.sv
// rtl/calc_sseg_scan.sv - registered calculator with sequential BCD conversion and scanned 7-seg readout
module calc_sseg_scan #(
    parameter int N           = 8,
    parameter int NDIG        = 5,
    parameter int REFRESH_CNT = 100000
) (
    input  logic         clk,
    input  logic         reset,
    calc_sseg_if.slave   bus
);
    localparam int W  = 2 * N;
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(W + 1);
    localparam int PW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    typedef enum logic [1:0] {IDLE, CALC, CONV, LOAD} state_t;

    state_t          state, state_next;
    logic [N-1:0]    xl, yl;
    logic [1:0]      opl;
    logic [W-1:0]    sh;
    logic [BW-1:0]   bcd, bcd_adj;
    logic [CW-1:0]   cnt;
    logic            neg_w, cout_w, ovf_w;
    logic [BW-1:0]   dig;
    logic            neg_d, cout_q, ovf_q, done_q, busy_q;
    logic [PW-1:0]   pre;
    logic [2:0]      idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = CALC;
            CALC: state_next = CONV;
            CONV: if (cnt == CW'(W - 1)) state_next = LOAD;
            LOAD: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [N:0]   sum;
    logic [N-1:0] diff;
    logic [W-1:0] r_c;
    logic         neg_c, cout_c, ovf_c;

    assign sum  = {1'b0, xl} + {1'b0, yl};
    assign diff = xl - yl;

    always_comb begin
        r_c    = '0;
        neg_c  = 1'b0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
        case (opl)
            2'b00: begin
                r_c    = {{(W-N-1){1'b0}}, sum};
                cout_c = sum[N];
                ovf_c  = (xl[N-1] == yl[N-1]) && (sum[N-1] != xl[N-1]);
            end
            2'b01: begin
                if (xl >= yl) begin
                    r_c    = {{N{1'b0}}, diff};
                    cout_c = 1'b1;
                end else begin
                    r_c   = {{N{1'b0}}, yl - xl};
                    neg_c = 1'b1;
                end
                ovf_c = (xl[N-1] != yl[N-1]) && (diff[N-1] != xl[N-1]);
            end
            2'b10: begin
                r_c   = W'(xl) * W'(yl);
                ovf_c = |r_c[W-1:N];
            end
            default: r_c = {{N{1'b0}}, xl & yl};
        endcase
    end

    // Add-3 correction applied to every nibble before each shift of the double-dabble.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xl     <= '0;
            yl     <= '0;
            opl    <= '0;
            sh     <= '0;
            bcd    <= '0;
            cnt    <= '0;
            neg_w  <= 1'b0;
            cout_w <= 1'b0;
            ovf_w  <= 1'b0;
            dig    <= '0;
            neg_d  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            done_q <= (state == LOAD);
            busy_q <= (state_next != IDLE) || (state == LOAD);
            case (state)
                IDLE: if (bus.start) begin
                    xl  <= bus.x;
                    yl  <= bus.y;
                    opl <= bus.op_sel;
                end
                CALC: begin
                    sh     <= r_c;
                    bcd    <= '0;
                    cnt    <= '0;
                    neg_w  <= neg_c;
                    cout_w <= cout_c;
                    ovf_w  <= ovf_c;
                end
                CONV: begin
                    bcd <= {bcd_adj[BW-2:0], sh[W-1]};
                    sh  <= {sh[W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                end
                LOAD: begin
                    dig    <= bcd;
                    neg_d  <= neg_w;
                    cout_q <= cout_w;
                    ovf_q  <= ovf_w;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PW'(REFRESH_CNT - 1)) begin
            pre <= '0;
            idx <= (idx == 3'(NDIG - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Bit i set when digit i and every digit above it are zero; digit 0 never blanks.
    function automatic logic [NDIG-1:0] blank_mask(input logic [BW-1:0] d);
        logic run;
        blank_mask = '0;
        run = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            run = run && (d[4*i +: 4] == 4'd0);
            blank_mask[i] = run;
        end
    endfunction

    logic [NDIG-1:0] blank;
    logic [3:0]      nib;
    logic            cur_blank, cur_minus;

    always_comb begin
        blank     = blank_mask(dig);
        nib       = dig[int'(idx)*4 +: 4];
        cur_blank = blank[idx];
        cur_minus = 1'b0;
        if (cur_blank && neg_d)
            cur_minus = (idx == 3'd1) || !blank[idx - 3'd1];
        if (cur_minus)      bus.sseg = 7'b0111111;
        else if (cur_blank) bus.sseg = 7'h7F;
        else begin
            case (nib)
                4'd0: bus.sseg = 7'b1000000;
                4'd1: bus.sseg = 7'b1111001;
                4'd2: bus.sseg = 7'b0100100;
                4'd3: bus.sseg = 7'b0110000;
                4'd4: bus.sseg = 7'b0011001;
                4'd5: bus.sseg = 7'b0010010;
                4'd6: bus.sseg = 7'b0000010;
                4'd7: bus.sseg = 7'b1111000;
                4'd8: bus.sseg = 7'b0000000;
                4'd9: bus.sseg = 7'b0010000;
                default: bus.sseg = 7'h7F;
            endcase
        end
    end

    assign bus.an    = ~(8'd1 << idx);
    assign bus.DP    = !((idx == 3'd0) && ovf_q);
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.cout  = cout_q;
    assign bus.overf = ovf_q;
endmodule
